// File: rtl/chip8_stack_pkg.sv
// chip8_stack_pkg
// Shared types and defaults for the CHIP-8 CALL/RET controller.
//   stk_op_t : command issued to the return-address stack (idle/push/pop)
//   state_t  : controller FSM states
//   DEF_*    : default parameter values for chip8_call_ctrl
package chip8_stack_pkg;

    typedef enum logic [1:0] {
        STK_IDLE = 2'd0,
        STK_PUSH = 2'd1,
        STK_POP  = 2'd2
    } stk_op_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PUSH1  = 3'd1,
        PUSH2  = 3'd2,
        POP1   = 3'd3,
        POP2   = 3'd4,
        RDWAIT = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam int DEF_STACK_DEPTH = 16;
    localparam int DEF_RD_LAT      = 2;

    // Stack command presented while the controller sits in a given state.
    function automatic stk_op_t op_for_state(input state_t s);
        case (s)
            PUSH1, PUSH2: op_for_state = STK_PUSH;
            POP1, POP2:   op_for_state = STK_POP;
            default:      op_for_state = STK_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/chip8_call_ctrl.sv
// chip8_call_ctrl
// Sequences CHIP-8 CALL/RET instructions against an external return-address
// stack owned by the parent CPU. Tracks stack occupancy and flags
// overflow/underflow (sticky until reset).
// Ports:
//   cpu_clk, reset          clock, asynchronous active-high reset
//   call_req, ret_req       single-cycle requests from the decoder (CALL wins)
//   cur_pc, target_addr     PC of executing instruction, CALL target nnn
//   stk_op, stk_wdata       stack command (0 idle/1 push/2 pop) and push data
//   stk_rdata               data returned by the stack after a pop
//   busy, done, pc_load     sequence status; done/pc_load are one-cycle pulses
//   new_pc                  CALL target or popped return address
//   depth                   occupied stack entries
//   err_overflow/underflow  sticky error flags
module chip8_call_ctrl
    import chip8_stack_pkg::*;
#(
    parameter int STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int RD_LAT      = DEF_RD_LAT
) (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic        call_req,
    input  logic        ret_req,
    input  logic [15:0] cur_pc,
    input  logic [11:0] target_addr,
    output logic [1:0]  stk_op,
    output logic [15:0] stk_wdata,
    input  logic [15:0] stk_rdata,
    output logic        busy,
    output logic        done,
    output logic        pc_load,
    output logic [15:0] new_pc,
    output logic [4:0]  depth,
    output logic        err_overflow,
    output logic        err_underflow
);

    // A zero-latency stack still needs a legal (1-bit) counter vector.
    localparam int              CNT_W    = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);
    localparam logic [4:0]       FULL     = 5'(STACK_DEPTH);

    state_t           state_q,   state_d;
    stk_op_t          stk_op_q,  stk_op_d;
    logic [15:0]      wdata_q,   wdata_d;
    logic [11:0]      tgt_q,     tgt_d;
    logic [15:0]      new_pc_q,  new_pc_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             pc_load_q, pc_load_d;
    logic [4:0]       depth_q,   depth_d;
    logic             ovf_q,     ovf_d;
    logic             unf_q,     unf_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    // Next-state logic. Registered outputs are derived from the next state so
    // that they line up with the state they describe.
    always_comb begin
        state_d   = state_q;
        wdata_d   = wdata_q;
        tgt_d     = tgt_q;
        new_pc_d  = new_pc_q;
        depth_d   = depth_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        cnt_d     = cnt_q;
        pc_load_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (call_req) begin
                    if (depth_q == FULL) begin
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        // Return address is the instruction after the CALL.
                        wdata_d = cur_pc + 16'd2;
                        tgt_d   = target_addr;
                        state_d = PUSH1;
                    end
                end else if (ret_req) begin
                    if (depth_q == 5'd0) begin
                        unf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = POP1;
                    end
                end
            end
            PUSH1: state_d = PUSH2;
            PUSH2: begin
                depth_d   = depth_q + 5'd1;
                new_pc_d  = {4'h0, tgt_q};
                pc_load_d = 1'b1;
                state_d   = DONE;
            end
            POP1: begin
                depth_d = depth_q - 5'd1;
                state_d = POP2;
            end
            POP2: begin
                if (RD_LAT == 0) begin
                    new_pc_d  = stk_rdata;
                    pc_load_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = RDWAIT;
                end
            end
            RDWAIT: begin
                // Last wait cycle: stack read data is valid now.
                if (cnt_q == '0) begin
                    new_pc_d  = stk_rdata;
                    pc_load_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        stk_op_d = op_for_state(state_d);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            stk_op_q  <= STK_IDLE;
            wdata_q   <= 16'h0000;
            tgt_q     <= 12'h000;
            new_pc_q  <= 16'h0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pc_load_q <= 1'b0;
            depth_q   <= 5'd0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            stk_op_q  <= stk_op_d;
            wdata_q   <= wdata_d;
            tgt_q     <= tgt_d;
            new_pc_q  <= new_pc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pc_load_q <= pc_load_d;
            depth_q   <= depth_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            cnt_q     <= cnt_d;
        end
    end

    assign stk_op        = stk_op_q;
    assign stk_wdata     = wdata_q;
    assign new_pc        = new_pc_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pc_load       = pc_load_q;
    assign depth         = depth_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;

endmodule

// File: tb/tb_chip8_call_ctrl.sv
// tb_chip8_call_ctrl
// Directed vector table, multi-cycle corner sequences and randomized CALL/RET
// traffic checked against a transaction-level model of the return stack.
module tb_chip8_call_ctrl;

    localparam int SD  = 16;
    localparam int RDL = 2;

    logic        cpu_clk;
    logic        reset;
    logic        call_req;
    logic        ret_req;
    logic [15:0] cur_pc;
    logic [11:0] target_addr;
    logic [1:0]  stk_op;
    logic [15:0] stk_wdata;
    logic [15:0] stk_rdata;
    logic        busy;
    logic        done;
    logic        pc_load;
    logic [15:0] new_pc;
    logic [4:0]  depth;
    logic        err_overflow;
    logic        err_underflow;

    chip8_call_ctrl #(.STACK_DEPTH(SD), .RD_LAT(RDL)) dut (
        .cpu_clk      (cpu_clk),
        .reset        (reset),
        .call_req     (call_req),
        .ret_req      (ret_req),
        .cur_pc       (cur_pc),
        .target_addr  (target_addr),
        .stk_op       (stk_op),
        .stk_wdata    (stk_wdata),
        .stk_rdata    (stk_rdata),
        .busy         (busy),
        .done         (done),
        .pc_load      (pc_load),
        .new_pc       (new_pc),
        .depth        (depth),
        .err_overflow (err_overflow),
        .err_underflow(err_underflow)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    // Environment: a simple stack that pushes/pops once per command burst and
    // presents popped data on stk_rdata.
    logic [15:0] env_mem [0:31];
    int          env_sp;
    logic [1:0]  env_prev;

    always @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            env_sp   = 0;
            env_prev = 2'd0;
        end else begin
            if (stk_op == 2'd1 && env_prev != 2'd1 && env_sp < 32) begin
                env_mem[env_sp] = stk_wdata;
                env_sp = env_sp + 1;
            end
            if (stk_op == 2'd2 && env_prev != 2'd2 && env_sp > 0) begin
                env_sp = env_sp - 1;
                stk_rdata <= env_mem[env_sp];
            end
            env_prev = stk_op;
        end
    end

    typedef struct {
        bit          call;
        bit          ret;
        bit          noise;
        logic [15:0] pc;
        logic [11:0] tgt;
        int          lat;
        int          npush;
        int          npop;
        bit          pcl;
        logic [15:0] wdata;
        logic [15:0] npc;
        logic [4:0]  dep;
        bit          ovf;
        bit          unf;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(bit c, bit r, bit n, logic [15:0] pc, logic [11:0] tgt,
                                int lat, int np, int npo, bit pcl, logic [15:0] wd,
                                logic [15:0] npc, logic [4:0] dep, bit ovf, bit unf);
        vec_t v;
        v.call = c; v.ret = r; v.noise = n; v.pc = pc; v.tgt = tgt;
        v.lat = lat; v.npush = np; v.npop = npo; v.pcl = pcl; v.wdata = wd;
        v.npc = npc; v.dep = dep; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    // Reference model: the stack is a queue of return addresses.
    logic [15:0] m_stk[$];
    bit          m_ovf;
    bit          m_unf;

    function automatic void model_reset();
        m_stk.delete();
        m_ovf = 0;
        m_unf = 0;
    endfunction

    function automatic vec_t model_step(bit c, bit r, bit n, logic [15:0] pc, logic [11:0] tgt);
        vec_t v;
        v = mk(c, r, n, pc, tgt, 1, 0, 0, 0, 16'h0, 16'h0, 5'd0, 0, 0);
        if (c) begin
            if (m_stk.size() == SD) begin
                m_ovf = 1;
            end else begin
                v.wdata = pc + 16'd2;
                m_stk.push_back(v.wdata);
                v.lat = 3; v.npush = 2; v.pcl = 1;
                v.npc = {4'h0, tgt};
            end
        end else if (r) begin
            if (m_stk.size() == 0) begin
                m_unf = 1;
            end else begin
                v.npc = m_stk.pop_back();
                v.lat = 3 + RDL; v.npop = 2; v.pcl = 1;
            end
        end
        v.dep = 5'(m_stk.size());
        v.ovf = m_ovf;
        v.unf = m_unf;
        return v;
    endfunction

    // Issue one request (caller is just after a rising edge, DUT idle) and
    // follow it until done, then confirm return to idle.
    task automatic run_op(input string tag, input vec_t v);
        int   pushes, pops, wbad, busylow, lat;
        bit   got_done;
        logic g_pcl, g_ovf, g_unf;
        logic [15:0] g_npc;
        logic [4:0]  g_dep;
        call_req = v.call; ret_req = v.ret; cur_pc = v.pc; target_addr = v.tgt;
        @(posedge cpu_clk); #1;
        call_req = 0; ret_req = 0;
        cur_pc = 16'($urandom); target_addr = 12'($urandom);
        pushes = 0; pops = 0; wbad = 0; busylow = 0; lat = 0; got_done = 0;
        g_pcl = 0; g_ovf = 0; g_unf = 0; g_npc = 0; g_dep = 0;
        for (int k = 1; k <= 20 && !got_done; k++) begin
            if (k == 2) begin call_req = 0; ret_req = 0; end
            if (!busy) busylow++;
            if (stk_op == 2'd1) begin
                pushes++;
                if (stk_wdata !== v.wdata) wbad++;
            end
            if (stk_op == 2'd2) pops++;
            if (done) begin
                got_done = 1; lat = k;
                g_pcl = pc_load; g_npc = new_pc; g_dep = depth;
                g_ovf = err_overflow; g_unf = err_underflow;
            end else begin
                if (k == 1 && v.noise) begin call_req = 1; ret_req = 1; end
                @(posedge cpu_clk); #1;
            end
        end
        call_req = 0; ret_req = 0;
        check({tag, " done_seen"}, 32'(got_done), 32'd1);
        check({tag, " latency"},   32'(lat),      32'(v.lat));
        check({tag, " push_cyc"},  32'(pushes),   32'(v.npush));
        check({tag, " pop_cyc"},   32'(pops),     32'(v.npop));
        check({tag, " busy_low"},  32'(busylow),  32'd0);
        if (v.npush > 0) check({tag, " wdata"}, 32'(wbad), 32'd0);
        check({tag, " pc_load"},   32'(g_pcl),    32'(v.pcl));
        if (v.pcl) check({tag, " new_pc"}, 32'(g_npc), 32'(v.npc));
        check({tag, " depth"},     32'(g_dep),    32'(v.dep));
        check({tag, " ovf"},       32'(g_ovf),    32'(v.ovf));
        check({tag, " unf"},       32'(g_unf),    32'(v.unf));
        @(posedge cpu_clk); #1;
        check({tag, " idle_after"}, {29'd0, busy, done, pc_load}, 32'd0);
        check({tag, " op_after"},   32'(stk_op), 32'd0);
        check({tag, " dep_after"},  32'(depth),  32'(v.dep));
    endtask

    task automatic apply_reset();
        reset = 1; call_req = 0; ret_req = 0;
        repeat (2) @(posedge cpu_clk);
        #1;
        reset = 0;
        model_reset();
    endtask

    vec_t tbl [7];
    vec_t v;
    int   pushes_seen, dones_seen;

    initial begin
        reset = 1; call_req = 0; ret_req = 0; cur_pc = 0; target_addr = 0;
        stk_rdata = 16'h0000;

        tbl[0] = mk(0, 1, 0, 16'h0000, 12'h000, 1,       0, 0, 0, 16'h0000, 16'h0000, 5'd0, 0, 1);
        tbl[1] = mk(1, 0, 0, 16'h0200, 12'h3A0, 3,       2, 0, 1, 16'h0202, 16'h03A0, 5'd1, 0, 1);
        tbl[2] = mk(0, 1, 0, 16'h0500, 12'h000, 3 + RDL, 0, 2, 1, 16'h0000, 16'h0202, 5'd0, 0, 1);
        tbl[3] = mk(1, 0, 0, 16'hFFFE, 12'hFFF, 3,       2, 0, 1, 16'h0000, 16'h0FFF, 5'd1, 0, 1);
        tbl[4] = mk(1, 1, 1, 16'h1234, 12'h456, 3,       2, 0, 1, 16'h1236, 16'h0456, 5'd2, 0, 1);
        tbl[5] = mk(0, 1, 0, 16'h0000, 12'h000, 3 + RDL, 0, 2, 1, 16'h0000, 16'h1236, 5'd1, 0, 1);
        tbl[6] = mk(0, 1, 1, 16'h0000, 12'h000, 3 + RDL, 0, 2, 1, 16'h0000, 16'h0000, 5'd0, 0, 1);

        // Reset values while reset is held.
        repeat (2) @(posedge cpu_clk);
        #1;
        check("rst stk_op",  32'(stk_op),    32'd0);
        check("rst wdata",   32'(stk_wdata), 32'd0);
        check("rst new_pc",  32'(new_pc),    32'd0);
        check("rst flags",   {26'd0, busy, done, pc_load, err_overflow, err_underflow, 1'b0}, 32'd0);
        check("rst depth",   32'(depth),     32'd0);
        reset = 0;
        model_reset();

        for (int i = 0; i < 7; i++)
            run_op($sformatf("vec%0d", i), tbl[i]);

        // Fill to capacity, then one CALL too many.
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            v = model_step(1, 0, 0, 16'(16'h0300 + 16'(i * 2)), 12'(12'h100 + 12'(i)));
            run_op($sformatf("fill%0d", i), v);
        end
        check("fill depth_final", 32'(depth), 32'(SD));

        // Reset in the middle of a push.
        apply_reset();
        call_req = 1; cur_pc = 16'h0300; target_addr = 12'h123;
        @(posedge cpu_clk); #1;
        call_req = 0;
        @(posedge cpu_clk); #1;
        check("midrst pre_op", 32'(stk_op), 32'd1);
        reset = 1;
        #1;
        check("midrst op",    32'(stk_op), 32'd0);
        check("midrst depth", 32'(depth),  32'd0);
        check("midrst busy",  32'(busy),   32'd0);
        @(posedge cpu_clk); #1;
        reset = 0;
        pushes_seen = 0; dones_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge cpu_clk); #1;
            if (stk_op != 2'd0) pushes_seen++;
            if (done) dones_seen++;
        end
        check("midrst no_op_after",   32'(pushes_seen), 32'd0);
        check("midrst no_done_after", 32'(dones_seen),  32'd0);
        model_reset();

        // Randomized traffic against the model.
        apply_reset();
        for (int i = 0; i < 80; i++) begin
            int  r;
            bit  c, rt;
            r  = $urandom_range(0, 99);
            c  = (r < 55) || (r >= 90);
            rt = (r >= 55);
            v  = model_step(c, rt, 1'($urandom_range(0, 1)), 16'($urandom), 12'($urandom));
            run_op($sformatf("rnd%0d", i), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chip8_call_ctrl.md
CHIP8_CALL_CTRL -- requirements
Module: chip8_call_ctrl

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 16, the number of return-address entries.
REQ-002 SHALL have parameter RD_LAT, default 2, the idle wait cycles after a pop before stk_rdata is sampled.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: cpu_clk and reset.
REQ-004 cpu_clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 call_req  input  1  single-cycle CALL request from the decoder.
REQ-007 ret_req  input  1  single-cycle RET request from the decoder.
REQ-008 cur_pc  input  16  PC of the executing instruction.
REQ-009 target_addr  input  12  CALL target nnn.
REQ-010 stk_op  output  2  stack command: 0 idle, 1 push, 2 pop.
REQ-011 stk_wdata  output  16  return address to the stack.
REQ-012 stk_rdata  input  16  popped data from the stack.
REQ-013 busy  output  1  sequence in progress.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 pc_load  output  1  one-cycle pulse, new_pc valid.
REQ-016 new_pc  output  16  next PC: CALL target or popped return address.
REQ-017 depth  output  5  occupied entries, 0..STACK_DEPTH.
REQ-018 err_overflow  output  1  sticky: CALL issued while full.
REQ-019 err_underflow  output  1  sticky: RET issued while empty.

Function
REQ-020 All outputs SHALL be registered.
REQ-021 The FSM SHALL have states IDLE, PUSH1, PUSH2, POP1, POP2, RDWAIT and DONE.
REQ-022 Requests SHALL be sampled only in IDLE; requests arriving while busy=1 SHALL be ignored.
REQ-023 If call_req and ret_req are both high in IDLE, CALL SHALL win and RET SHALL be dropped.
REQ-024 A legal CALL (depth<STACK_DEPTH) SHALL go IDLE->PUSH1->PUSH2->DONE.
REQ-025 During a CALL, stk_op=1 SHALL be held in PUSH1 and PUSH2, with stk_wdata=cur_pc+2 (16-bit, wraps) captured at accept.
REQ-026 A CALL SHALL increment depth on exit from PUSH2.
REQ-027 In DONE for a CALL, new_pc={4'h0,target_addr}, pc_load=1 and done=1.
REQ-028 A legal RET (depth>0) SHALL go IDLE->POP1->POP2->RDWAIT(RD_LAT cycles)->DONE.
REQ-029 During a RET, stk_op=2 SHALL be held in POP1 and POP2 only, and depth SHALL decrement on exit from POP1.
REQ-030 stk_rdata SHALL be captured in the last RDWAIT cycle; in DONE, new_pc=captured value, pc_load=1 and done=1.
REQ-031 A CALL at depth==STACK_DEPTH SHALL set err_overflow and go IDLE->DONE with done=1, pc_load=0, no stack op and depth unchanged.
REQ-032 A RET at depth==0 SHALL set err_underflow and go IDLE->DONE with done=1, pc_load=0, no stack op and depth unchanged.
REQ-033 busy SHALL be 1 in every state except IDLE; DONE SHALL always return to IDLE.
REQ-034 Latency, request cycle to done: CALL 3 cycles; RET 3+RD_LAT cycles; error 1 cycle.
REQ-035 stk_op SHALL be 0 in all states other than PUSH1, PUSH2, POP1 and POP2.

Reset
REQ-036 Reset SHALL force state=IDLE, stk_op=0, stk_wdata=0, new_pc=0, busy=0, done=0, pc_load=0, depth=0, err_overflow=0 and err_underflow=0.
REQ-037 Reset mid-sequence SHALL abandon the operation with no further stack command.
REQ-038 Stack pointer realignment after reset is done by the CPU-level reset of both blocks.
REQ-039 Error flags SHALL clear only on reset.

Structure
REQ-040 Package chip8_stack_pkg SHALL hold the stk_op_t enum (STK_IDLE, STK_PUSH, STK_POP), the FSM state enum, and the defaults STACK_DEPTH and RD_LAT.
REQ-041 No sub-module is required; the stack instance lives in the parent CPU.
REQ-042 The RDWAIT counter SHALL be an inline counter of width $clog2(RD_LAT+1).

Verification
REQ-043 CALL with cur_pc=16'h0200 and target=12'h3A0 -> stk_op=1 for exactly 2 cycles with stk_wdata=16'h0202, then done+pc_load with new_pc=16'h03A0 and depth=1.
REQ-044 RET following that CALL, with stk_rdata model returning 16'h0202 -> stk_op=2 for 2 cycles, then done at request+5 (RD_LAT=2) with new_pc=16'h0202 and depth=0.
REQ-045 Seventeen CALLs from reset -> depth=16; the 17th gives err_overflow=1, pc_load=0 and no stk_op activity.
REQ-046 RET from reset -> err_underflow=1, done one cycle later, stk_op stays 0.
REQ-047 call_req and ret_req together at depth=1 -> push only, depth=2; a call_req pulsed during busy -> ignored.
REQ-048 Reset asserted during PUSH2 -> stk_op=0 immediately, depth=0, busy=0, and no done pulse.
